// File: rtl/mlp_train_sequencer_pkg.sv
// Shared types and saturating signed fixed-point (Q8.8) helpers for the MLP training sequencer.
package mlp_train_sequencer_pkg;

    localparam int unsigned SFP_W    = 16;
    localparam int unsigned SFP_FRAC = 8;

    typedef logic signed [SFP_W-1:0] sfp;

    localparam sfp ONE     = 16'sh0100;
    localparam sfp SFP_MAX = 16'sh7fff;
    localparam sfp SFP_MIN = 16'sh8000;

    typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

    function automatic sfp sfp_sat(input logic signed [31:0] x);
        if (x > 32'sd32767) begin
            return SFP_MAX;
        end else if (x < -32'sd32768) begin
            return SFP_MIN;
        end
        return sfp'(x[SFP_W-1:0]);
    endfunction

    function automatic sfp sfp_add(input sfp a, input sfp b);
        logic signed [31:0] s;
        s = 32'(a) + 32'(b);
        return sfp_sat(s);
    endfunction

    function automatic sfp sfp_sub(input sfp a, input sfp b);
        logic signed [31:0] s;
        s = 32'(a) - 32'(b);
        return sfp_sat(s);
    endfunction

    function automatic sfp sfp_mul(input sfp a, input sfp b);
        logic signed [31:0] p;
        p = 32'(a) * 32'(b);
        return sfp_sat(p >>> SFP_FRAC);
    endfunction

endpackage

// File: rtl/mlp_train_sequencer_sample_store.sv
// Sample register file: one write port, one asynchronous read port, cleared by reset or clear.
module mlp_train_sequencer_sample_store #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 48,
    parameter int unsigned AddrW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             we,
    input  logic [AddrW-1:0] waddr,
    input  logic [Width-1:0] wdata,
    input  logic [AddrW-1:0] raddr,
    output logic [Width-1:0] rdata
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-power-of-two depths leave unused addresses; they read as zero.
    always_comb begin
        rdata = '0;
        if (32'(raddr) < Depth) begin
            rdata = mem[raddr];
        end
    end

endmodule

// File: rtl/mlp_train_sequencer.sv
// Presents stored samples to the MLP core for training or inference and counts epochs.
// Define MLP_SEQ_LOSS_EN to add the per-epoch squared-error loss outputs.
module mlp_train_sequencer
    import mlp_train_sequencer_pkg::*;
#(
    parameter int unsigned Inputs       = 2,
    parameter int unsigned Outputs      = 1,
    parameter int unsigned Depth        = 4,
    parameter int unsigned SettleCycles = 2,
    parameter int unsigned MaxEpochs    = 1000,
    localparam int unsigned IdxW        = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW        = $clog2(Depth + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [Inputs*SFP_W-1:0]  load_values,
    input  logic [Outputs*SFP_W-1:0] load_expected,
    input  logic                     start,
    input  logic                     infer_only,
    input  logic                     stop,
    input  logic [SFP_W-1:0]         lr_in,
    output logic [Inputs*SFP_W-1:0]  values,
    output logic [Outputs*SFP_W-1:0] expected,
    output logic                     training,
    output logic [SFP_W-1:0]         learning_rate,
    input  logic [Outputs*SFP_W-1:0] prediction,
    output logic                     busy,
    output logic                     done,
    output logic [31:0]              epoch,
    output logic [IdxW-1:0]          sample_idx,
`ifdef MLP_SEQ_LOSS_EN
    output logic [SFP_W-1:0]         epoch_loss,
    output logic                     loss_valid,
`endif
    output logic [CntW-1:0]          count
);

    localparam int unsigned InW  = Inputs * SFP_W;
    localparam int unsigned OutW = Outputs * SFP_W;
    localparam int unsigned SetW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;

    seq_state_t      state_q, state_d;
    logic [CntW-1:0] count_q, count_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [SetW-1:0] settle_q, settle_d;
    logic [31:0]     epoch_q, epoch_d;
    logic [SFP_W-1:0] lr_q, lr_d;
    logic            infer_q, infer_d;
    logic [InW-1:0]  values_q, values_d;
    logic [OutW-1:0] expected_q, expected_d;
    logic            training_q, training_d;

    logic                store_we, store_clear;
    logic [InW+OutW-1:0] rd_data;
    logic                run_start, capture, epoch_end, abort;

    mlp_train_sequencer_sample_store #(
        .Depth (Depth),
        .Width (InW + OutW),
        .AddrW (IdxW)
    ) u_sample_store (
        .clk   (clk),
        .rst   (rst),
        .clear (store_clear),
        .we    (store_we),
        .waddr (count_q[IdxW-1:0]),
        .wdata ({load_expected, load_values}),
        .raddr (idx_d),
        .rdata (rd_data)
    );

    assign load_ready = (state_q == IDLE) && (32'(count_q) < Depth);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        settle_d    = settle_q;
        epoch_d     = epoch_q;
        lr_d        = lr_q;
        infer_d     = infer_q;
        store_we    = 1'b0;
        store_clear = 1'b0;
        run_start   = 1'b0;
        capture     = 1'b0;
        epoch_end   = 1'b0;
        abort       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clear) begin
                    count_d     = '0;
                    store_clear = 1'b1;
                end else begin
                    if (load_valid && load_ready) begin
                        store_we = 1'b1;
                        count_d  = count_q + 1'b1;
                    end
                    if (start && (count_q != '0)) begin
                        state_d   = RUN;
                        run_start = 1'b1;
                        lr_d      = lr_in;
                        infer_d   = infer_only;
                        epoch_d   = '0;
                        idx_d     = '0;
                        settle_d  = '0;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = DONE;
                    abort   = 1'b1;
                end else if (settle_q == SetW'(SettleCycles - 1)) begin
                    capture  = 1'b1;
                    settle_d = '0;
                    if (32'(idx_q) + 32'd1 == 32'(count_q)) begin
                        epoch_end = 1'b1;
                        idx_d     = '0;
                        epoch_d   = epoch_q + 32'd1;
                        if ((epoch_q + 32'd1 == MaxEpochs) || infer_q) begin
                            state_d = DONE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // MLP-facing outputs are registered from the next-state view so a sample
    // appears the cycle after start.
    always_comb begin
        values_d   = '0;
        expected_d = '0;
        training_d = 1'b0;
        if (state_d == RUN) begin
            values_d   = rd_data[InW-1:0];
            expected_d = rd_data[InW +: OutW];
            training_d = !infer_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            idx_q      <= '0;
            settle_q   <= '0;
            epoch_q    <= '0;
            lr_q       <= '0;
            infer_q    <= 1'b0;
            values_q   <= '0;
            expected_q <= '0;
            training_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            settle_q   <= settle_d;
            epoch_q    <= epoch_d;
            lr_q       <= lr_d;
            infer_q    <= infer_d;
            values_q   <= values_d;
            expected_q <= expected_d;
            training_q <= training_d;
        end
    end

    assign values        = values_q;
    assign expected      = expected_q;
    assign training      = training_q;
    assign learning_rate = lr_q;
    assign busy          = (state_q == RUN);
    assign done          = (state_q == DONE);
    assign epoch         = epoch_q;
    assign sample_idx    = idx_q;
    assign count         = count_q;

`ifdef MLP_SEQ_LOSS_EN
    sfp   acc_q, acc_d, loss_q, loss_d;
    logic loss_valid_q, loss_valid_d;

    always_comb begin
        sfp sq_sum;
        sfp err;
        sfp total;
        sq_sum       = '0;
        err          = '0;
        total        = '0;
        acc_d        = acc_q;
        loss_d       = loss_q;
        loss_valid_d = 1'b0;
        for (int i = 0; i < int'(Outputs); i++) begin
            err    = sfp_sub(sfp'(expected_q[i*SFP_W +: SFP_W]),
                             sfp'(prediction[i*SFP_W +: SFP_W]));
            sq_sum = sfp_add(sq_sum, sfp_mul(err, err));
        end
        total = sfp_add(acc_q, sq_sum);
        if (run_start || abort) begin
            acc_d = '0;
        end else if (capture) begin
            if (epoch_end) begin
                loss_d       = total;
                acc_d        = '0;
                loss_valid_d = 1'b1;
            end else begin
                acc_d = total;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q        <= '0;
            loss_q       <= '0;
            loss_valid_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            loss_q       <= loss_d;
            loss_valid_q <= loss_valid_d;
        end
    end

    assign epoch_loss = loss_q;
    assign loss_valid = loss_valid_q;
`else
    // Prediction only feeds the loss path; keep it visibly consumed.
    logic unused_pred;
    assign unused_pred = ^{prediction, run_start, capture, epoch_end, abort};
`endif

endmodule
